// File: rtl/rs_slot_scheduler.sv
// Reservation-station slot scheduler: tracks occupancy, picks the lowest free slot for dispatch,
// and offers one operand-ready entry per cycle to the function unit in round-robin order.
module rs_slot_scheduler #(
    parameter int RS_SIZE = 4,
    parameter int IDX_W   = $clog2(RS_SIZE)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    output logic               alloc_ready,
    output logic [IDX_W-1:0]   alloc_index,
    input  logic               alloc_taken,
    input  logic [RS_SIZE-1:0] entry_ready,
    output logic               issue_valid,
    output logic [IDX_W-1:0]   issue_index,
    input  logic               issue_ack,
    output logic [RS_SIZE-1:0] busy_vec,
    output logic [IDX_W:0]     free_count
);

    logic [RS_SIZE-1:0] busy;
    logic [RS_SIZE-1:0] busy_next;
    logic [RS_SIZE-1:0] cand;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   rr_pick;
    logic [IDX_W-1:0]   scan_idx;
    logic               rr_hit;
    logic               lock_valid;
    logic [IDX_W-1:0]   lock_index;

    assign busy_vec    = busy;
    assign cand        = busy & entry_ready;
    assign alloc_ready = |(~busy);

    // Scanning downward leaves the lowest free slot as the final assignment.
    always_comb begin
        alloc_index = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) alloc_index = IDX_W'(i);
        end
    end

    always_comb begin
        free_count = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            free_count = free_count + (IDX_W + 1)'(~busy[i]);
        end
    end

    // Index arithmetic wraps naturally because RS_SIZE is a power of two.
    always_comb begin
        rr_pick  = '0;
        rr_hit   = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < RS_SIZE; k++) begin
            scan_idx = rr_ptr + IDX_W'(k);
            if (!rr_hit && cand[scan_idx]) begin
                rr_pick = scan_idx;
                rr_hit  = 1'b1;
            end
        end
    end

    always_comb begin
        issue_valid = lock_valid ? 1'b1 : rr_hit;
        issue_index = lock_valid ? lock_index : rr_pick;
    end

    always_comb begin
        busy_next = busy;
        if (alloc_taken && alloc_ready) busy_next[alloc_index] = 1'b1;
        if (issue_valid && issue_ack)   busy_next[issue_index] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= '0;
            rr_ptr     <= '0;
            lock_valid <= 1'b0;
            lock_index <= '0;
        end else if (flush) begin
            busy       <= '0;
            rr_ptr     <= '0;
            lock_valid <= 1'b0;
            lock_index <= '0;
        end else begin
            busy <= busy_next;
            if (issue_valid && issue_ack) begin
                lock_valid <= 1'b0;
                rr_ptr     <= issue_index + IDX_W'(1);
            end else if (issue_valid) begin
                lock_valid <= 1'b1;
                lock_index <= issue_index;
            end
        end
    end

endmodule

// File: tb/tb_rs_slot_scheduler.sv
// Testbench for rs_slot_scheduler: directed vector table, async-reset check, and randomized
// traffic compared against a slot-list reference model.
module tb_rs_slot_scheduler;

    localparam int RS_SIZE = 4;
    localparam int IDX_W   = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic               alloc_ready;
    logic [IDX_W-1:0]   alloc_index;
    logic               alloc_taken;
    logic [RS_SIZE-1:0] entry_ready;
    logic               issue_valid;
    logic [IDX_W-1:0]   issue_index;
    logic               issue_ack;
    logic [RS_SIZE-1:0] busy_vec;
    logic [IDX_W:0]     free_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rs_slot_scheduler #(.RS_SIZE(RS_SIZE), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_ready(alloc_ready), .alloc_index(alloc_index), .alloc_taken(alloc_taken),
        .entry_ready(entry_ready),
        .issue_valid(issue_valid), .issue_index(issue_index), .issue_ack(issue_ack),
        .busy_vec(busy_vec), .free_count(free_count)
    );

    typedef struct {
        logic       fl;
        logic       at;
        logic       ack;
        logic [3:0] er;
        logic       ar;
        logic [1:0] ai;
        logic       iv;
        logic [1:0] ii;
        logic [3:0] bv;
        logic [2:0] fc;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: one flag per slot plus pointer and held offer.
    bit m_busy[RS_SIZE];
    int m_rr;
    bit m_lock;
    int m_lidx;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic f, input logic at, input logic ack, input logic [3:0] er);
        flush       = f;
        alloc_taken = at;
        issue_ack   = ack;
        entry_ready = er;
        #2;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAll(input string tag, input logic ar, input logic [1:0] ai, input logic iv,
                            input logic [1:0] ii, input logic [3:0] bv, input logic [2:0] fc);
        checkOutput({tag, " alloc_ready"}, 32'(alloc_ready), 32'(ar));
        checkOutput({tag, " alloc_index"}, 32'(alloc_index), 32'(ai));
        checkOutput({tag, " issue_valid"}, 32'(issue_valid), 32'(iv));
        checkOutput({tag, " issue_index"}, 32'(issue_index), 32'(ii));
        checkOutput({tag, " busy_vec"},    32'(busy_vec),    32'(bv));
        checkOutput({tag, " free_count"},  32'(free_count),  32'(fc));
    endtask

    task automatic addVec(input logic fl, input logic at, input logic ack, input logic [3:0] er,
                          input logic ar, input logic [1:0] ai, input logic iv, input logic [1:0] ii,
                          input logic [3:0] bv, input logic [2:0] fc);
        vec_t v;
        v = '{fl, at, ack, er, ar, ai, iv, ii, bv, fc};
        vecs.push_back(v);
    endtask

    task automatic modelReset();
        for (int i = 0; i < RS_SIZE; i++) m_busy[i] = 1'b0;
        m_rr   = 0;
        m_lock = 1'b0;
        m_lidx = 0;
    endtask

    initial begin
        logic       e_ar, e_iv, r_fl, r_at, r_ack;
        logic [1:0] e_ai, e_ii;
        logic [3:0] e_bv, r_er;
        logic [2:0] e_fc;

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        //     fl at ack er       ar ai iv ii bv       fc
        addVec(0, 1, 0, 4'b0000, 1, 0, 0, 0, 4'b0000, 4);
        addVec(0, 1, 0, 4'b0000, 1, 1, 0, 0, 4'b0001, 3);
        addVec(0, 1, 0, 4'b0000, 1, 2, 0, 0, 4'b0011, 2);
        addVec(0, 1, 0, 4'b0000, 1, 3, 0, 0, 4'b0111, 1);
        addVec(0, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b1111, 0);
        addVec(0, 0, 1, 4'b1010, 0, 0, 1, 1, 4'b1111, 0);
        addVec(0, 0, 1, 4'b1010, 1, 1, 1, 3, 4'b1101, 1);
        addVec(0, 0, 0, 4'b0000, 1, 1, 0, 0, 4'b0101, 2);
        addVec(0, 0, 0, 4'b0100, 1, 1, 1, 2, 4'b0101, 2);
        addVec(0, 0, 0, 4'b0001, 1, 1, 1, 2, 4'b0101, 2);
        addVec(0, 0, 0, 4'b0001, 1, 1, 1, 2, 4'b0101, 2);
        addVec(0, 0, 1, 4'b0001, 1, 1, 1, 2, 4'b0101, 2);
        addVec(0, 1, 0, 4'b0000, 1, 1, 0, 0, 4'b0001, 3);
        addVec(0, 1, 0, 4'b0000, 1, 2, 0, 0, 4'b0011, 2);
        addVec(0, 1, 1, 4'b0001, 1, 3, 1, 0, 4'b0111, 1);
        addVec(0, 0, 0, 4'b0000, 1, 0, 0, 0, 4'b1110, 1);
        addVec(0, 0, 0, 4'b0010, 1, 0, 1, 1, 4'b1110, 1);
        addVec(1, 1, 1, 4'b0010, 1, 0, 1, 1, 4'b1110, 1);
        addVec(0, 0, 0, 4'b1111, 1, 0, 0, 0, 4'b0000, 4);
        addVec(0, 1, 0, 4'b0000, 1, 0, 0, 0, 4'b0000, 4);
        addVec(0, 1, 0, 4'b0000, 1, 1, 0, 0, 4'b0001, 3);
        addVec(0, 1, 0, 4'b0000, 1, 2, 0, 0, 4'b0011, 2);
        addVec(0, 1, 0, 4'b0000, 1, 3, 0, 0, 4'b0111, 1);
        addVec(0, 0, 1, 4'b1111, 0, 0, 1, 0, 4'b1111, 0);
        addVec(0, 0, 1, 4'b1111, 1, 0, 1, 1, 4'b1110, 1);
        addVec(0, 0, 0, 4'b0000, 1, 0, 0, 0, 4'b1100, 2);

        foreach (vecs[n]) begin
            applyStimulus(vecs[n].fl, vecs[n].at, vecs[n].ack, vecs[n].er);
            checkAll($sformatf("vec%0d", n), vecs[n].ar, vecs[n].ai, vecs[n].iv,
                     vecs[n].ii, vecs[n].bv, vecs[n].fc);
            stepClock();
        end

        // Build busy=1011 from 1100, then pulse reset between edges.
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000); stepClock();
        applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000); stepClock();
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0100); stepClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
        checkOutput("pre_reset busy_vec", 32'(busy_vec), 32'(4'b1011));
        rst = 1'b1;
        #1;
        checkOutput("async_reset busy_vec",    32'(busy_vec),    32'(4'b0000));
        checkOutput("async_reset alloc_ready", 32'(alloc_ready), 32'(1'b1));
        checkOutput("async_reset free_count",  32'(free_count),  32'(3'd4));
        checkOutput("async_reset issue_valid", 32'(issue_valid), 32'(1'b0));
        rst = 1'b0;
        stepClock();

        modelReset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            int nfree, first_free, pick;
            nfree      = 0;
            first_free = -1;
            e_bv       = '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                e_bv[i] = m_busy[i];
                if (!m_busy[i]) begin
                    nfree++;
                    if (first_free < 0) first_free = i;
                end
            end
            e_ar = (nfree > 0);
            e_ai = (first_free < 0) ? 2'd0 : 2'(first_free);
            e_fc = 3'(nfree);

            r_er  = 4'($urandom_range(0, 15));
            r_fl  = ($urandom_range(0, 19) == 0);
            r_at  = e_ar && ($urandom_range(0, 1) == 1);
            r_ack = ($urandom_range(0, 2) != 0);

            pick = -1;
            for (int k = 0; k < RS_SIZE; k++) begin
                int s;
                s = (m_rr + k) % RS_SIZE;
                if (pick < 0 && m_busy[s] && r_er[s]) pick = s;
            end
            if (m_lock) begin
                e_iv = 1'b1;
                e_ii = 2'(m_lidx);
            end else begin
                e_iv = (pick >= 0);
                e_ii = (pick >= 0) ? 2'(pick) : 2'd0;
            end

            applyStimulus(r_fl, r_at, r_ack, r_er);
            checkAll($sformatf("rand%0d", cyc), e_ar, e_ai, e_iv, e_ii, e_bv, e_fc);

            if (r_fl) begin
                modelReset();
            end else begin
                if (r_at && e_ar) m_busy[e_ai] = 1'b1;
                if (e_iv && r_ack) begin
                    m_busy[e_ii] = 1'b0;
                    m_lock       = 1'b0;
                    m_rr         = (int'(e_ii) + 1) % RS_SIZE;
                end else if (e_iv) begin
                    m_lock = 1'b1;
                    m_lidx = int'(e_ii);
                end
            end
            stepClock();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
